mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port main-memory access port between C core requesters.
- Each core issues a read or write with a req/ack handshake. The arbiter latches the winner's command, drives the memory port for a fixed access latency, and returns read data with a one-cycle ack.
- Sits between the per-core memory stages and the shared data memory.

Parameters:
- C, 8, number of requesters (2..8).
- LAT, 2, memory access cycles per transaction (>=1).
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  in  1  clock, all flops on posedge.
- reset  in  1  reset, synchronous, active-high.
- req  in  C  per-requester request; held until ack.
- we  in  C  per-requester write (1) / read (0).
- adr  in  C x AW  per-requester address.
- wdat  in  C x DW  per-requester write data.
- gnt  out  C  one-hot; grant held for the whole transaction.
- ack  out  C  one-hot one-cycle completion pulse.
- rdat  out  DW  read data; valid in the ack cycle.
- mem_adr  out  AW  memory address.
- mem_wdat  out  DW  memory write data.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_rdat  in  DW  memory read data.

Behaviour:
- Reset: all outputs are 0 (gnt, ack, rdat, mem_adr, mem_wdat, mem_we, mem_re). State is IDLE. Pointer ptr = C-1, so requester 0 wins first.
- State machine: two states, IDLE and BUSY. A 3-bit down-counter cnt tracks the access.
- IDLE arbitration:
  - Eligible set = req & ~ack. A requester being acked this cycle is masked out.
  - Winner sel = first eligible index scanning ptr+1, ptr+2, ... modulo C.
  - If none is eligible, stay in IDLE.
  - Otherwise, at the edge: latch sel, we[sel], adr[sel], wdat[sel]; set gnt = 1<<sel; cnt = LAT-1; go to BUSY.
- BUSY:
  - mem_adr and mem_wdat are driven from the latched values for the whole of BUSY.
  - mem_we or mem_re (per the latched we) is high only in the first BUSY cycle.
  - cnt decrements each cycle.
  - At the edge where cnt==0:
    - For reads, rdat <= mem_rdat. For writes, rdat holds its previous value.
    - ack <= 1<<sel; gnt <= 0; ptr <= sel; go to IDLE.
- Timing: request seen in IDLE cycle t. gnt and strobe are high in cycle t+1. ack and rdat appear in cycle t+LAT+1. Sustained throughput is one transaction per LAT+1 cycles.
- ack is a single-cycle pulse. Outside ack cycles, rdat holds its last value.
- Requester rules:
  - A requester deasserting req while granted has no effect; the latched transaction completes and is acked.
  - A requester keeping req high after ack is re-arbitrated from the next cycle, behind all others in rotation.
- Fairness: with all C requesting, grants rotate strictly 0,1,...,C-1,0. Worst-case wait is (C-1)*(LAT+1) cycles after first eligibility.
- Pointer wrap: ptr = C-1 wraps the scan to index 0.
- Reset mid-BUSY: the transaction is aborted. No ack is issued, gnt and strobes are 0 from the next cycle, and ptr returns to C-1.
- Unused upper bits of gnt and ack are 0 when C < 8.

Optional Feature:
- Macro: MEM_ARB_WRITE_FIRST_EN.
- Defined: in IDLE, if any eligible requester has we=1, the round-robin scan covers only eligible writers. Reads are granted only when no eligible write is pending. ptr is shared across both classes.
- Not defined: plain round-robin, independent of we.

Test Plan:
- Single read: req[3]=1, we[3]=0, adr[3]=0x0040, memory returns 0xBEEF.
  -> gnt=0x08 for LAT cycles; mem_re high in the first grant cycle only; ack=0x08 and rdat=0xBEEF at cycle t+LAT+1.
- Single write: req[0]=1, we[0]=1, adr=0x0123, wdat=0x5A5A.
  -> mem_we pulse with mem_adr=0x0123 and mem_wdat=0x5A5A; ack=0x01; rdat unchanged.
- All 8 requesting continuously, LAT=2.
  -> grant order 0..7,0; one ack every 3 cycles; no ack for requester i between its consecutive grants.
- req[5] held after ack while req[2] is asserted the same cycle.
  -> requester 2 granted next; requester 5 is not re-granted in the ack cycle.
- reset asserted in the second BUSY cycle.
  -> gnt=0, no ack, mem_we=mem_re=0 next cycle; after release, requester 0 wins when 0 and 4 request.
- MEM_ARB_WRITE_FIRST_EN: read req[1] and write req[6] both pending.
  -> requester 6 granted first, then requester 1; without the macro, requester 1 is granted first.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// ============================================================================
// Module   : mem_rr_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one single-port memory
//            between C requesters. Optional macro: MEM_ARB_WRITE_FIRST_EN
//            (eligible writes take precedence over reads).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_rr_arbiter #(
  parameter int C   = 8,
  parameter int LAT = 2,
  parameter int AW  = 16,
  parameter int DW  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [C-1:0]         i_req,
  input  logic [C-1:0]         i_we,
  input  logic [C-1:0][AW-1:0] i_adr,
  input  logic [C-1:0][DW-1:0] i_wdat,
  output logic [C-1:0]         o_gnt,
  output logic [C-1:0]         o_ack,
  output logic [DW-1:0]        o_rdat,
  output logic [AW-1:0]        o_mem_adr,
  output logic [DW-1:0]        o_mem_wdat,
  output logic                 o_mem_we,
  output logic                 o_mem_re,
  input  logic [DW-1:0]        i_mem_rdat
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [2:0]   c_PTR_RST  = 3'(C - 1);
  localparam logic [2:0]   c_CNT_LOAD = 3'(LAT - 1);
  localparam logic [C-1:0] c_ONE      = C'(1);

  state_t         r_state;
  logic [2:0]     r_cnt;
  logic [2:0]     r_ptr;
  logic [2:0]     r_sel;
  logic           r_we;
  logic [AW-1:0]  r_adr;
  logic [DW-1:0]  r_wdat;
  logic [DW-1:0]  r_rdat;
  logic [C-1:0]   r_gnt;
  logic [C-1:0]   r_ack;
  logic           r_mem_we;
  logic           r_mem_re;

  logic [C-1:0]   w_elig;
  logic [C-1:0]   w_cand;
  logic [7:0]     w_cand8;
  logic [2:0]     w_idx;
  logic [2:0]     w_sel;
  logic           w_found;
  logic           w_sel_we;
  logic [AW-1:0]  w_sel_adr;
  logic [DW-1:0]  w_sel_wdat;

  function automatic logic [C-1:0] f_onehot(input logic [2:0] idx);
    return c_ONE << idx;
  endfunction

  // A requester being acked this cycle must not win again immediately.
  always_comb begin
    w_elig = i_req & ~r_ack;
`ifdef MEM_ARB_WRITE_FIRST_EN
    w_cand = (|(w_elig & i_we)) ? (w_elig & i_we) : w_elig;
`else
    w_cand = w_elig;
`endif
    w_cand8 = 8'(w_cand);
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_idx   = '0;
    for (int k = 1; k <= C; k++) begin
      w_idx = 3'((int'(r_ptr) + k) % C);
      if (!w_found && w_cand8[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_adr  = '0;
    w_sel_wdat = '0;
    for (int i = 0; i < C; i++) begin
      if (w_sel == 3'(i)) begin
        w_sel_we   = i_we[i];
        w_sel_adr  = i_adr[i];
        w_sel_wdat = i_wdat[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ptr    <= c_PTR_RST;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_wdat   <= '0;
      r_rdat   <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
    end else begin
      r_ack    <= '0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_sel    <= w_sel;
            r_we     <= w_sel_we;
            r_adr    <= w_sel_adr;
            r_wdat   <= w_sel_wdat;
            r_gnt    <= f_onehot(w_sel);
            r_cnt    <= c_CNT_LOAD;
            r_mem_we <= w_sel_we;
            r_mem_re <= ~w_sel_we;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == 3'd0) begin
            if (!r_we) begin
              r_rdat <= i_mem_rdat;
            end
            r_ack   <= f_onehot(r_sel);
            r_gnt   <= '0;
            r_ptr   <= r_sel;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt      = r_gnt;
  assign o_ack      = r_ack;
  assign o_rdat     = r_rdat;
  assign o_mem_adr  = r_adr;
  assign o_mem_wdat = r_wdat;
  assign o_mem_we   = r_mem_we;
  assign o_mem_re   = r_mem_re;

endmodule

`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
// ============================================================================
// Module   : tb_mem_rr_arbiter
// Brief    : Self-checking bench for mem_rr_arbiter against a transaction-level
//            reference model (honours MEM_ARB_WRITE_FIRST_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_rr_arbiter;
  localparam int C   = 8;
  localparam int LAT = 2;
  localparam int AW  = 16;
  localparam int DW  = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [C-1:0]         req, we;
  logic [C-1:0][AW-1:0] adr;
  logic [C-1:0][DW-1:0] wdat;
  logic [C-1:0]         gnt, ack;
  logic [DW-1:0]        rdat, mem_wdat, mem_rdat;
  logic [AW-1:0]        mem_adr;
  logic                 mem_we, mem_re;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.C(C), .LAT(LAT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(req), .i_we(we), .i_adr(adr), .i_wdat(wdat),
    .o_gnt(gnt), .o_ack(ack), .o_rdat(rdat),
    .o_mem_adr(mem_adr), .o_mem_wdat(mem_wdat),
    .o_mem_we(mem_we), .o_mem_re(mem_re), .i_mem_rdat(mem_rdat)
  );

  // Bench-side memory: 256 words, combinational read.
  logic [DW-1:0] mem [256];
  logic          mem_init, pl_en;
  logic [7:0]    pl_a;
  logic [DW-1:0] pl_d;
  assign mem_rdat = mem[mem_adr[7:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 16'((k * 40503) ^ 16'h1234);
    end else if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (mem_we) begin
      mem[mem_adr[7:0]] <= mem_wdat;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: the most recent transaction and its timing window.
  int            t_start = -100;
  int            t_id = 0;
  bit            t_we = 1'b0;
  logic [AW-1:0] t_adr = '0;
  logic [DW-1:0] t_wdat = '0, t_rd = '0;
  logic [DW-1:0] m_rdat = '0;
  int            m_ptr = C - 1;
  logic [DW-1:0] m_mem [256];
  logic [C-1:0]  one = 1;
  bit [C-1:0]    out_st = '0;

  function automatic bit m_busy(input int n);
    return (n > t_start) && (n <= t_start + LAT);
  endfunction

  function automatic bit m_ack_at(input int n);
    return n == t_start + LAT + 1;
  endfunction

  task automatic arbitrate();
    logic [C-1:0] el;
    int           win;
    el = req;
    if (m_ack_at(cyc)) el = el & ~(one << t_id);
`ifdef MEM_ARB_WRITE_FIRST_EN
    if ((el & we) != '0) el = el & we;
`endif
    win = -1;
    for (int k = 1; k <= C; k++) begin
      if (win < 0 && el[(m_ptr + k) % C]) win = (m_ptr + k) % C;
    end
    if (win >= 0) begin
      t_start = cyc;
      t_id    = win;
      t_we    = we[win];
      t_adr   = adr[win];
      t_wdat  = wdat[win];
      if (t_we) m_mem[t_adr[7:0]] = t_wdat;
      else      t_rd = m_mem[t_adr[7:0]];
      m_ptr   = win;
    end
  endtask

  // Evaluate the model for the current cycle, advance one clock, check outputs.
  task automatic cycle();
    logic [C-1:0] e_gnt, e_ack;
    if (reset) begin
      t_start = -100;
      m_ptr   = C - 1;
      m_rdat  = '0;
    end else if (!m_busy(cyc)) begin
      arbitrate();
    end
    @(posedge clk);
    #1;
    cyc++;
    e_gnt = m_busy(cyc) ? (one << t_id) : '0;
    e_ack = m_ack_at(cyc) ? (one << t_id) : '0;
    if (m_ack_at(cyc) && !t_we) m_rdat = t_rd;
    check_eq("gnt", 32'(gnt), 32'(e_gnt));
    check_eq("ack", 32'(ack), 32'(e_ack));
    check_eq("rdat", 32'(rdat), 32'(m_rdat));
    check_eq("mem_we", 32'(mem_we), 32'(cyc == t_start + 1 && t_we));
    check_eq("mem_re", 32'(mem_re), 32'(cyc == t_start + 1 && !t_we));
    if (m_busy(cyc)) begin
      check_eq("mem_adr", 32'(mem_adr), 32'(t_adr));
      if (t_we) check_eq("mem_wdat", 32'(mem_wdat), 32'(t_wdat));
    end
  endtask

  task automatic new_cmd(input int i);
    we[i]   = 1'($urandom_range(1, 0));
    adr[i]  = 16'($urandom_range(31, 0));
    wdat[i] = 16'($urandom);
  endtask

  task automatic run_until_ack(input int i, output int lat, output bit seen);
    seen = 1'b0;
    lat  = -1;
    for (int k = 0; k < (C + 1) * (LAT + 1) + 4 && !seen; k++) begin
      cycle();
      if (ack[i]) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check_eq("ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain();
    req = '0;
    for (int k = 0; k < LAT + 2; k++) cycle();
  endtask

  initial begin
    int lat, n_acks, exp_idx;
    bit seen;
    reset = 1'b1; mem_init = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0;
    req = '0; we = '0; adr = '0; wdat = '0;
    for (int k = 0; k < 256; k++) m_mem[k] = 16'((k * 40503) ^ 16'h1234);
    cycle();
    mem_init = 1'b0;
    cycle();
    reset = 1'b0;
    check_eq("rst_mem_adr", 32'(mem_adr), 32'd0);
    check_eq("rst_mem_wdat", 32'(mem_wdat), 32'd0);

    // Single read from 0x0040 returning 0xBEEF.
    pl_en = 1'b1; pl_a = 8'h40; pl_d = 16'hBEEF; m_mem[8'h40] = 16'hBEEF;
    cycle();
    pl_en = 1'b0;
    req[3] = 1'b1; we[3] = 1'b0; adr[3] = 16'h0040;
    run_until_ack(3, lat, seen);
    check_eq("rd_lat", 32'(lat), 32'(LAT));
    check_eq("rd_beef", 32'(rdat), 32'hBEEF);
    req[3] = 1'b0;

    // Single write; rdat must keep the previous read value.
    req[0] = 1'b1; we[0] = 1'b1; adr[0] = 16'h0123; wdat[0] = 16'h5A5A;
    run_until_ack(0, lat, seen);
    check_eq("wr_rdat_hold", 32'(rdat), 32'hBEEF);
    req[0] = 1'b0;
    drain();

    // All requesters continuously: strict rotation from requester 0.
    do_reset();
    for (int i = 0; i < C; i++) new_cmd(i);
    req = '1;
    n_acks = 0; exp_idx = 0;
    for (int k = 0; k < 10 * (LAT + 1); k++) begin
      cycle();
      if (ack != '0) begin
        check_eq("rr_order", 32'(ack), 32'(one << (exp_idx % C)));
        exp_idx++;
        n_acks++;
        for (int i = 0; i < C; i++) if (ack[i]) new_cmd(i);
      end
    end
    check_eq("rr_count", 32'(n_acks), 32'd10);
    drain();

    // Requester 5 keeps req after ack while 2 arrives in the ack cycle.
    req[5] = 1'b1; new_cmd(5);
    run_until_ack(5, lat, seen);
    req[2] = 1'b1; new_cmd(2);
    cycle();
    check_eq("hold_gnt", 32'(gnt), 32'(one << 2));
    run_until_ack(2, lat, seen);
    req[2] = 1'b0;
    run_until_ack(5, lat, seen);
    req[5] = 1'b0;
    drain();

    // Reset in the second BUSY cycle aborts the transaction.
    req[3] = 1'b1; new_cmd(3);
    cycle();
    cycle();
    reset = 1'b1; req[3] = 1'b0;
    cycle();
    reset = 1'b0;
    check_eq("rstmid_gnt", 32'(gnt), 32'd0);
    req[0] = 1'b1; new_cmd(0); req[4] = 1'b1; new_cmd(4);
    cycle();
    check_eq("rstmid_win", 32'(gnt), 32'(one));
    run_until_ack(0, lat, seen);
    req[0] = 1'b0;
    run_until_ack(4, lat, seen);
    req[4] = 1'b0;
    drain();

    // Read on 1 and write on 6 pending together.
    do_reset();
    req[1] = 1'b1; we[1] = 1'b0; adr[1] = 16'h0011;
    req[6] = 1'b1; we[6] = 1'b1; adr[6] = 16'h0016; wdat[6] = 16'hC0DE;
    cycle();
`ifdef MEM_ARB_WRITE_FIRST_EN
    check_eq("wf_first", 32'(gnt), 32'(one << 6));
`else
    check_eq("wf_first", 32'(gnt), 32'(one << 1));
`endif
    for (int k = 0; k < 4 * (LAT + 1) && req != '0; k++) begin
      cycle();
      for (int i = 0; i < C; i++) if (ack[i]) req[i] = 1'b0;
    end
    check_eq("wf_done", 32'(req), 32'd0);
    drain();

    // Randomised traffic: hold until ack, occasional drop while granted.
    out_st = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < C; i++) begin
        if (m_ack_at(cyc) && t_id == i) begin
          out_st[i] = 1'b0;
          if ($urandom_range(1, 0) == 1) begin
            new_cmd(i); req[i] = 1'b1; out_st[i] = 1'b1;
          end else begin
            req[i] = 1'b0;
          end
        end else if (out_st[i]) begin
          if (m_busy(cyc) && t_id == i && $urandom_range(7, 0) == 0) req[i] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          new_cmd(i); req[i] = 1'b1; out_st[i] = 1'b1;
        end
      end
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
